// File: rtl/branch_predictor_table_ram_pkg.sv
// Shared types and helpers for the branch predictor table RAM.
// Optional feature macro: BRANCH_PREDICTOR_PARITY_EN (per-way even parity bit).
package branch_predictor_table_ram_pkg;

    localparam int ENTRY_WIDTH  = 20;
    localparam int PARITY_MAX_W = 64;

    typedef logic [ENTRY_WIDTH-1:0] entry_t;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } bp_state_e;

    // Callers zero-extend narrower entries into the fixed-width argument.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/branch_predictor_table_ram_if.sv
// Fetch/branch-unit facing bundle of the branch predictor table RAM.
// Optional feature macro: BRANCH_PREDICTOR_PARITY_EN (drives parity_error when set).
interface branch_predictor_table_ram_if #(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 512,
    parameter int WAYS       = 2
);
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ADDR_W = $clog2(DEPTH);

    logic                       init_done;
    logic                       read_en;
    logic [ADDR_W-1:0]          read_addr;
    logic [WAYS*DATA_WIDTH-1:0] read_data;
    logic                       read_valid;
    logic                       write_en;
    logic [ADDR_W-1:0]          write_addr;
    logic [WAY_W-1:0]           write_way;
    logic [DATA_WIDTH-1:0]      write_data;
    logic [WAYS-1:0]            parity_error;

    modport master (
        output read_en, read_addr, write_en, write_addr, write_way, write_data,
        input  init_done, read_data, read_valid, parity_error
    );

    modport slave (
        input  read_en, read_addr, write_en, write_addr, write_way, write_data,
        output init_done, read_data, read_valid, parity_error
    );

endinterface

// File: rtl/branch_predictor_way_ram.sv
// One predictor way: simple dual-port array, registered read, optional parity bit.
// Optional feature macro: BRANCH_PREDICTOR_PARITY_EN.
module branch_predictor_way_ram
    import branch_predictor_table_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     rd_par_err
);

`ifdef BRANCH_PREDICTOR_PARITY_EN
    localparam int STORE_W = DATA_WIDTH + 1;
`else
    localparam int STORE_W = DATA_WIDTH;
`endif

    logic [STORE_W-1:0]    mem_r [DEPTH];
    logic [STORE_W-1:0]    wr_word_s;
    logic [STORE_W-1:0]    rd_word_s;
    logic                  rd_par_err_s;
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic                  rd_par_err_r;

    assign rd_word_s = mem_r[rd_addr];

`ifdef BRANCH_PREDICTOR_PARITY_EN
    logic [PARITY_MAX_W-1:0] wr_ext_s;
    logic [PARITY_MAX_W-1:0] rd_ext_s;

    // Parity bit generation on write and check on read
    always_comb begin
        wr_ext_s = '0;
        wr_ext_s[DATA_WIDTH-1:0] = wr_data;
        rd_ext_s = '0;
        rd_ext_s[DATA_WIDTH-1:0] = rd_word_s[DATA_WIDTH-1:0];
        wr_word_s    = {even_parity(wr_ext_s), wr_data};
        rd_par_err_s = even_parity(rd_ext_s) ^ rd_word_s[DATA_WIDTH];
    end
`else
    // Plain storage: word is the entry itself, no parity check
    always_comb begin
        wr_word_s    = wr_data;
        rd_par_err_s = 1'b0;
    end
`endif

    // Array write port; the array itself is never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_word_s;
        end
    end

    // Registered read port, holds its value between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r    <= '0;
            rd_par_err_r <= 1'b0;
        end else if (rd_en) begin
            rd_data_r    <= rd_word_s[DATA_WIDTH-1:0];
            rd_par_err_r <= rd_par_err_s;
        end
    end

    assign rd_data    = rd_data_r;
    assign rd_par_err = rd_par_err_r;

endmodule

// File: rtl/branch_predictor_table_ram.sv
// Multi-way branch predictor table: clear sweep FSM, write decode, write-first bypass.
// Optional feature macro: BRANCH_PREDICTOR_PARITY_EN (per-way parity check).
module branch_predictor_table_ram
    import branch_predictor_table_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 20,
    parameter int DEPTH      = 512,
    parameter int WAYS       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    branch_predictor_table_ram_if.slave   bus
);

    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ADDR_W = $clog2(DEPTH);

    bp_state_e                  state_r;
    bp_state_e                  state_s;
    logic [ADDR_W-1:0]          clear_idx_r;
    logic [ADDR_W-1:0]          clear_idx_s;
    logic                       ready_s;
    logic                       read_fire_s;
    logic [WAYS-1:0]            way_we_s;
    logic [ADDR_W-1:0]          way_waddr_s;
    logic [DATA_WIDTH-1:0]      way_wdata_s;
    logic [DATA_WIDTH-1:0]      way_rdata_s [WAYS];
    logic [WAYS-1:0]            way_perr_s;
    logic [WAYS-1:0]            bypass_hit_r;
    logic [DATA_WIDTH-1:0]      bypass_data_r;
    logic                       read_valid_r;
    logic [WAYS*DATA_WIDTH-1:0] read_data_s;
    logic [WAYS-1:0]            parity_error_s;

    // Sweep sequencing: CLEAR walks every index once, then READY until reset
    always_comb begin
        state_s     = state_r;
        clear_idx_s = clear_idx_r;
        case (state_r)
            CLEAR: begin
                clear_idx_s = clear_idx_r + ADDR_W'(1);
                if (clear_idx_r == ADDR_W'(DEPTH - 1)) begin
                    state_s = READY;
                end else begin
                    state_s = CLEAR;
                end
            end
            READY: begin
                state_s = READY;
            end
            default: begin
                state_s     = CLEAR;
                clear_idx_s = '0;
            end
        endcase
    end

    // FSM state and clear counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= CLEAR;
            clear_idx_r <= '0;
        end else begin
            state_r     <= state_s;
            clear_idx_r <= clear_idx_s;
        end
    end

    // Write port steering: sweep owns every way during CLEAR
    always_comb begin
        ready_s     = (state_r == READY);
        read_fire_s = ready_s && bus.read_en;
        way_waddr_s = ready_s ? bus.write_addr : clear_idx_r;
        way_wdata_s = ready_s ? bus.write_data : '0;
        way_we_s    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ready_s) begin
                way_we_s[w] = bus.write_en && (bus.write_way == WAY_W'(w));
            end else begin
                way_we_s[w] = 1'b1;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        branch_predictor_way_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (way_we_s[w]),
            .wr_addr    (way_waddr_s),
            .wr_data    (way_wdata_s),
            .rd_en      (read_fire_s),
            .rd_addr    (bus.read_addr),
            .rd_data    (way_rdata_s[w]),
            .rd_par_err (way_perr_s[w])
        );
    end

    // Registered collision compare and bypass payload, captured per accepted read
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_hit_r  <= '0;
            bypass_data_r <= '0;
            read_valid_r  <= 1'b0;
        end else begin
            read_valid_r <= read_fire_s;
            if (read_fire_s) begin
                bypass_hit_r  <= (bus.write_addr == bus.read_addr) ? way_we_s : '0;
                bypass_data_r <= bus.write_data;
            end
        end
    end

    // Output mux: bypassed ways show the fresh write and never a parity error
    always_comb begin
        read_data_s    = '0;
        parity_error_s = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (bypass_hit_r[w]) begin
                read_data_s[w*DATA_WIDTH +: DATA_WIDTH] = bypass_data_r;
                parity_error_s[w] = 1'b0;
            end else begin
                read_data_s[w*DATA_WIDTH +: DATA_WIDTH] = way_rdata_s[w];
                parity_error_s[w] = way_perr_s[w];
            end
        end
    end

    assign bus.init_done    = (state_r == READY);
    assign bus.read_valid   = read_valid_r;
    assign bus.read_data    = read_data_s;
    assign bus.parity_error = parity_error_s;

endmodule

// File: tb/tb_branch_predictor_table_ram.sv
// Scoreboard bench for branch_predictor_table_ram (DEPTH=16, WAYS=2) plus a WAYS=3
// instance for the out-of-range way drop; parity deposit runs with BRANCH_PREDICTOR_PARITY_EN.
module tb_branch_predictor_table_ram;

    typedef struct packed {
        logic [39:0] data;
        logic [1:0]  perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    branch_predictor_table_ram_if #(.DATA_WIDTH(20), .DEPTH(16), .WAYS(2)) bus ();
    branch_predictor_table_ram #(.DATA_WIDTH(20), .DEPTH(16), .WAYS(2)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    branch_predictor_table_ram_if #(.DATA_WIDTH(8), .DEPTH(4), .WAYS(3)) bus3 ();
    branch_predictor_table_ram #(.DATA_WIDTH(8), .DEPTH(4), .WAYS(3)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3)
    );

    // Monitor: every presented read result is matched against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (bus.read_valid === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_valid: read_valid=1 with data %h, none required", bus.read_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.read_data !== e.data || bus.parity_error !== e.perr) begin
                    miscompares++;
                    $display("FAIL read_result: got data=%h perr=%b, required data=%h perr=%b",
                             bus.read_data, bus.parity_error, e.data, e.perr);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic read_op(input logic [3:0] addr, input logic [39:0] data, input logic [1:0] perr);
        bus.read_en   = 1'b1;
        bus.read_addr = addr;
        exp_q.push_back('{data: data, perr: perr});
        tick();
        bus.read_en = 1'b0;
    endtask

    task automatic write_op(input logic [3:0] addr, input logic way, input logic [19:0] data);
        bus.write_en   = 1'b1;
        bus.write_addr = addr;
        bus.write_way  = way;
        bus.write_data = data;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic rw_op(input logic [3:0] raddr, input logic [3:0] waddr, input logic way,
                         input logic [19:0] wdata, input logic [39:0] data);
        bus.read_en    = 1'b1;
        bus.read_addr  = raddr;
        bus.write_en   = 1'b1;
        bus.write_addr = waddr;
        bus.write_way  = way;
        bus.write_data = wdata;
        exp_q.push_back('{data: data, perr: 2'b00});
        tick();
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
    endtask

    // Counts cycles until init_done; optionally pokes a write+read mid-sweep
    task automatic sweep_wait(input int inject_at, input string name);
        int k;
        k = 0;
        while (bus.init_done !== 1'b1 && k < 40) begin
            if (k + 1 == inject_at) begin
                bus.write_en   = 1'b1;
                bus.write_addr = 4'd3;
                bus.write_way  = 1'b0;
                bus.write_data = 20'h55555;
                bus.read_en    = 1'b1;
                bus.read_addr  = 4'd3;
            end
            tick();
            k++;
            bus.write_en = 1'b0;
            bus.read_en  = 1'b0;
            if (k == inject_at) begin
                check("clear_read_ignored", {63'd0, bus.read_valid}, 64'd0);
                check("clear_data_zero", {24'd0, bus.read_data}, 64'd0);
            end
        end
        check(name, 64'(k), 64'd16);
    endtask

    task automatic dut3_write(input logic [1:0] addr, input logic [1:0] way, input logic [7:0] data);
        bus3.write_en   = 1'b1;
        bus3.write_addr = addr;
        bus3.write_way  = way;
        bus3.write_data = data;
        tick();
        bus3.write_en = 1'b0;
    endtask

    task automatic dut3_read(input string name, input logic [1:0] addr, input logic [23:0] data);
        bus3.read_en   = 1'b1;
        bus3.read_addr = addr;
        tick();
        bus3.read_en = 1'b0;
        check({name, "_valid"}, {63'd0, bus3.read_valid}, 64'd1);
        check(name, {40'd0, bus3.read_data}, {40'd0, data});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bus.read_en = 1'b0;  bus.read_addr = '0;  bus.write_en = 1'b0;
        bus.write_addr = '0; bus.write_way = '0;  bus.write_data = '0;
        bus3.read_en = 1'b0; bus3.read_addr = '0; bus3.write_en = 1'b0;
        bus3.write_addr = '0; bus3.write_way = '0; bus3.write_data = '0;

        // Reset state and initial sweep, with an ignored write/read at sweep cycle 10
        rst = 1'b1;
        tick();
        tick();
        check("rst_init_done", {63'd0, bus.init_done}, 64'd0);
        check("rst_read_valid", {63'd0, bus.read_valid}, 64'd0);
        check("rst_read_data", {24'd0, bus.read_data}, 64'd0);
        check("rst_parity_error", {62'd0, bus.parity_error}, 64'd0);
        rst = 1'b0;
        sweep_wait(10, "sweep_cycles_initial");

        for (int i = 0; i < 16; i++) begin
            read_op(4'(i), 40'h0, 2'b00);
        end

        // Basic write then read, plus hold on an idle cycle
        write_op(4'd5, 1'b1, 20'hABCDE);
        read_op(4'd5, {20'hABCDE, 20'h00000}, 2'b00);
        check("basic_valid_latency", {63'd0, bus.read_valid}, 64'd1);
        tick();
        check("hold_valid_low", {63'd0, bus.read_valid}, 64'd0);
        check("hold_data", {24'd0, bus.read_data}, {24'd0, 20'hABCDE, 20'h00000});

        // Collisions: write-first on the targeted way only
        write_op(4'd7, 1'b1, 20'h0F0F0);
        rw_op(4'd7, 4'd7, 1'b0, 20'h12345, {20'h0F0F0, 20'h12345});
        read_op(4'd7, {20'h0F0F0, 20'h12345}, 2'b00);
        rw_op(4'd7, 4'd7, 1'b1, 20'h77777, {20'h77777, 20'h12345});
        read_op(4'd7, {20'h77777, 20'h12345}, 2'b00);
        rw_op(4'd5, 4'd6, 1'b0, 20'h11111, {20'hABCDE, 20'h00000});
        read_op(4'd6, {20'h00000, 20'h11111}, 2'b00);

        // Out-of-range way is dropped (WAYS=3 instance)
        dut3_write(2'd1, 2'd3, 8'hFF);
        dut3_write(2'd1, 2'd2, 8'h5A);
        dut3_read("badway_read", 2'd1, 24'h5A0000);
        dut3_write(2'd1, 2'd0, 8'h11);
        dut3_read("way0_read", 2'd1, 24'h5A0011);

        // Parity: clean entry, then corrupted stored bit, then bypass masking
        write_op(4'd2, 1'b1, 20'h00001);
        read_op(4'd2, {20'h00001, 20'h00000}, 2'b00);
`ifdef BRANCH_PREDICTOR_PARITY_EN
        dut.g_way[1].u_way.mem_r[2][0] = 1'b0;
        read_op(4'd2, {20'h00000, 20'h00000}, 2'b10);
`endif
        rw_op(4'd2, 4'd2, 1'b1, 20'h00003, {20'h00003, 20'h00000});
        read_op(4'd2, {20'h00003, 20'h00000}, 2'b00);

        // Reset at sweep cycle 8: sweep restarts from index 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        check("midsweep_init_done", {63'd0, bus.init_done}, 64'd0);
        rst = 1'b0;
        sweep_wait(0, "sweep_cycles_after_midsweep_rst");
        read_op(4'd5, 40'h0, 2'b00);
        read_op(4'd7, 40'h0, 2'b00);
        read_op(4'd6, 40'h0, 2'b00);

        // Reset one cycle after a read
        write_op(4'd9, 1'b0, 20'h00001);
        read_op(4'd9, {20'h00000, 20'h00001}, 2'b00);
        rst = 1'b1;
        tick();
        check("midop_read_valid", {63'd0, bus.read_valid}, 64'd0);
        check("midop_init_done", {63'd0, bus.init_done}, 64'd0);
        check("midop_read_data", {24'd0, bus.read_data}, 64'd0);
        rst = 1'b0;
        sweep_wait(0, "sweep_cycles_after_midop_rst");
        read_op(4'd9, 40'h0, 2'b00);

        tick();
        tick();
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_predictor_table_ram.md
Name: branch_predictor_table_ram

Overview:
Multi-way branch predictor storage array, parametrised in entry width, depth and way count.
- All ways are read in parallel at one index; one selected way is written per cycle.
- Guarantees write-first behaviour in synthesis and simulation alike through an explicit bypass.
- After reset, a hardware sweep clears every entry to zero.
- Sits between fetch (read port) and branch unit (write port on update or mispredict).

Parameters:
DATA_WIDTH, 20, bits per entry (tag + target + state), must be >= 1
DEPTH, 512, entries per way, power of two >= 2
WAYS, 2, number of ways, >= 1
WAY_W, (WAYS > 1 ? $clog2(WAYS) : 1), derived way-select width, not overridable

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
init_done  out  1  high once the clear sweep has finished
read_en  in  1  read request
read_addr  in  $clog2(DEPTH)  read index
read_data  out  WAYS*DATA_WIDTH  way w occupies bits [w*DATA_WIDTH +: DATA_WIDTH]
read_valid  out  1  read_data holds a result for the previous cycle's read_en
write_en  in  1  write request
write_addr  in  $clog2(DEPTH)  write index
write_way  in  WAY_W  target way
write_data  in  DATA_WIDTH  entry to write
parity_error  out  WAYS  per-way parity mismatch on the current read_data

Behaviour:
Reset values:
- rst high in any cycle, including mid-sweep or mid-read: FSM to CLEAR, clear_idx=0.
- init_done=0, read_valid=0, read_data=0, parity_error=0.

FSM states:
- CLEAR: each cycle, zero clear_idx in all ways; clear_idx++. When clear_idx==DEPTH-1, go to READY next cycle.
- READY: init_done=1; stays until rst. The sweep takes exactly DEPTH cycles after rst deasserts.
- In CLEAR, external write_en and read_en are ignored: no array write, read_valid stays 0, read_data stays 0.

Read (READY only):
- Latency 1.
- read_en at cycle N gives read_data and read_valid=1 at N+1.
- read_en=0 at N gives read_valid=0 at N+1; read_data holds its last value.

Write (READY only):
- write_en at N updates way write_way, index write_addr, at the N edge.
- write_way >= WAYS: write dropped (no way modified).

Collision:
- Same cycle with read_en, write_en and read_addr==write_addr: the targeted way returns write_data at N+1. Other ways return stored contents.
- The bypass is an explicit registered compare-and-mux, not reliant on blocking assignments.

Back-to-back:
- A write at N followed by a read of the same index at N+1 returns the new data, because the array is already updated.

Array inference:
- Each way is a simple dual-port block RAM with a registered read and no reset on the array.
- Only the sweep clears the array.

Optional Feature:
BRANCH_PREDICTOR_PARITY_EN
- Defined:
  - Each way stores one extra even-parity bit, computed on write_data (sweep writes parity 0).
  - On each valid read, parity_error[w] = parity of stored data XOR stored parity bit, registered alongside read_data.
  - Bypassed data always shows parity_error=0.
- Undefined: no extra bit stored; parity_error tied to 0. Port list is unchanged.

Decomposition:
- Shared package: an entry typedef (logic [DATA_WIDTH-1:0]), an FSM state enum {CLEAR, READY}, and a parity helper function.
- Natural sub-module branch_predictor_way_ram: one way with one write port, one registered read port and the optional parity bit, instantiated WAYS times.
- The top level holds the FSM, clear counter, write-way decode, bypass compare and output muxing.

Test Plan:
- Init sweep: DEPTH=16, WAYS=2; assert rst 1 cycle then release. Required: init_done=0 for 16 cycles, 1 on the 17th. Reading every index afterwards returns 0 in both ways.
- Basic read/write: write idx 5, way 1, 0xABCDE; next cycle read idx 5. Required: read_data way1=0xABCDE, way0=0, read_valid=1 exactly one cycle later.
- Collision: write idx 7, way 0, 0x12345 in the same cycle as a read of idx 7. Required: next cycle way0=0x12345 (write-first), way1 holds its old value.
- Reset mid-sweep / mid-op: assert rst at sweep cycle 8, and again one cycle after a read_en. Required: read_valid=0 next cycle, init_done=0, sweep restarts from 0 with 16 full cycles. Data written before rst reads back as 0.
- Ignored during CLEAR and bad way: write_en idx 3 during CLEAR, and in READY write with write_way=2 while WAYS=2. Required: idx 3 reads 0 in all ways afterwards.
- Parity (macro defined): write 0x00001, then force-flip stored bit 0 via hierarchical deposit and read. Required: parity_error[way]=1. Without the macro, parity_error stays 0.
